// File: rtl/de4_qsys_pkg.sv
// Shared types and constants for the DE4 system-ID checker.
package de4_qsys_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    GAP,
    FINISH
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // ts_en=0 means the timestamp word is not part of the image check.
  function automatic logic check_pass(input logic [31:0] id, input logic [31:0] ts,
                                      input logic [31:0] exp_id, input logic [31:0] exp_ts,
                                      input logic ts_en);
    return (id == exp_id) && (!ts_en || (ts == exp_ts));
  endfunction

endpackage

// File: rtl/de4_sysid_read_timer.sv
// Down-counter with terminal-count flag; times both read responses and the retry gap.
module de4_sysid_read_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/de4_qsys_sysid.sv
// System-ID checker: reads ID/timestamp words over Avalon-MM and reports pass/timeout.
// Timestamp check is included only when DE4_SYSID_CHECKER_TS_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// ID_REQ  | read of address 0 issued, waiting for acceptance
// ID_WAIT | ID read accepted, waiting for readdatavalid
// TS_REQ  | read of address 1 issued, waiting for acceptance
// TS_WAIT | timestamp read accepted, waiting for readdatavalid
// GAP     | quiet period after a timeout, late responses discarded
// FINISH  | result valid, done pulse
module de4_qsys_sysid_checker
  import de4_qsys_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1436718101,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_RETRIES    = 3,
  parameter int          GAP_CYCLES     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam int CNT_W = $clog2((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       MAX_RETRY = 4'(MAX_RETRIES);

  sysid_chk_state_t state;
  logic [3:0]       retry_cnt;
  logic             gap_to_ts;
  logic             in_req, in_wait, got_data;
  logic             tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0] tmr_val;

  assign in_req   = (state == ID_REQ) || (state == TS_REQ);
  assign in_wait  = (state == ID_WAIT) || (state == TS_WAIT);
  assign got_data = (in_req && !avm_waitrequest && avm_readdatavalid) ||
                    (in_wait && avm_readdatavalid);

  // Timer reloads on every entry into a REQ state or GAP; counts otherwise.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LOAD;
    tmr_en   = 1'b0;
    case (state)
      IDLE: tmr_load = start;
      ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
        if (got_data) begin
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_expired) tmr_load = 1'b1;
        else             tmr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  de4_sysid_read_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
      retry_cnt   <= '0;
      gap_to_ts   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ID_REQ;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
          end
        end
        ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
          if (got_data) begin
            if ((state == ID_REQ) || (state == ID_WAIT)) begin
              read_id <= avm_readdata;
`ifdef DE4_SYSID_CHECKER_TS_CHECK_EN
              state       <= TS_REQ;
              avm_read    <= 1'b1;
              avm_address <= SYSID_ADDR_TS;
`else
              state    <= FINISH;
              avm_read <= 1'b0;
              done     <= 1'b1;
              pass     <= check_pass(avm_readdata, read_ts, EXPECTED_ID, EXPECTED_TS, 1'b0);
`endif
            end else begin
              read_ts  <= avm_readdata;
              state    <= FINISH;
              avm_read <= 1'b0;
              done     <= 1'b1;
              pass     <= check_pass(read_id, avm_readdata, EXPECTED_ID, EXPECTED_TS, 1'b1);
            end
          end else if (tmr_expired) begin
            avm_read <= 1'b0;
            if (retry_cnt < MAX_RETRY) begin
              retry_cnt <= retry_cnt + 4'd1;
              gap_to_ts <= (state == TS_REQ) || (state == TS_WAIT);
              state     <= GAP;
            end else begin
              state       <= FINISH;
              done        <= 1'b1;
              timeout_err <= 1'b1;
              pass        <= 1'b0;
            end
          end else if (in_req && !avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= (state == ID_REQ) ? ID_WAIT : TS_WAIT;
          end
        end
        GAP: begin
          if (tmr_expired) begin
            state       <= gap_to_ts ? TS_REQ : ID_REQ;
            avm_read    <= 1'b1;
            avm_address <= gap_to_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de4_qsys_sysid_checker.sv
// Directed bench for de4_qsys_sysid_checker; follows DE4_SYSID_CHECKER_TS_CHECK_EN like the RTL.
module tb_de4_qsys_sysid_checker;

`ifdef DE4_SYSID_CHECKER_TS_CHECK_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [31:0] TS_OK = 32'd1436718101;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata, read_id, read_ts;
  logic        busy, done, pass, timeout_err;

  always #5 clock = ~clock;

  de4_qsys_sysid_checker dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout_err       (timeout_err),
    .read_id           (read_id),
    .read_ts           (read_ts)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle bookkeeping: rel cycle 0 is the cycle in which start is high.
  int tcyc = 0;
  int base = 0;
  initial forever begin
    @(posedge clock);
    tcyc++;
  end

  // Slave model
  logic [31:0] sl_id, sl_ts;
  int          sl_wait_left, sl_resp_from, sl_inject;
  bit          sl_same;
  logic        acc, acc_addr;
  int          rel_s;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      acc      = avm_read && !avm_waitrequest;
      acc_addr = avm_address;
      @(posedge clock);
      #1;
      rel_s             = tcyc - base;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      avm_waitrequest   = 1'b0;
      if (avm_read && !avm_address && sl_wait_left > 0) begin
        avm_waitrequest = 1'b1;
        sl_wait_left--;
      end
      if (sl_same) begin
        if (avm_read && !avm_waitrequest && rel_s >= sl_resp_from) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = avm_address ? sl_ts : sl_id;
        end
      end else if (acc && rel_s >= sl_resp_from) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = acc_addr ? sl_ts : sl_id;
      end
      if (rel_s == sl_inject) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = JUNK;
      end
    end
  end

  task automatic slave_cfg(input logic [31:0] id, input logic [31:0] ts, input int wait_c,
                           input bit same, input int resp_from, input int inject);
    sl_id = id; sl_ts = ts; sl_wait_left = wait_c;
    sl_same = same; sl_resp_from = resp_from; sl_inject = inject;
  endtask

  // Sequence monitor results
  int done_c, hi0, hi1, busy_low;
  int rises[$];

  task automatic run_seq(input int budget, input int restart_at);
    logic prev;
    done_c = -1; hi0 = 0; hi1 = 0; busy_low = 0; prev = 1'b0;
    rises.delete();
    @(posedge clock); #2; base = tcyc + 1;
    @(posedge clock); #2; start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clock); #2;
      start = (k == restart_at);
      if (avm_read) begin
        if (avm_address) hi1++;
        else             hi0++;
        if (!prev) rises.push_back(k);
      end
      prev = avm_read;
      if (!busy) busy_low++;
      if (done) begin
        done_c = k;
        break;
      end
    end
    start = 1'b0;
    check("seq_completed", done_c >= 0, 1);
    @(posedge clock); #2;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] id;
    logic [31:0] ts;
    int          wait_c;
    bit          same;
    int          done_full;
    int          done_id;
    bit          pass_full;
    bit          pass_id;
    int          hi0;
  } vec_t;

  vec_t vecs[5];

  task automatic apply_vec(input vec_t v);
    slave_cfg(v.id, v.ts, v.wait_c, v.same, 0, -1);
    run_seq(200, -1);
    check({v.name, "_done_cycle"}, done_c, TS_EN ? v.done_full : v.done_id);
    check({v.name, "_pass"}, pass, TS_EN ? v.pass_full : v.pass_id);
    check({v.name, "_timeout_err"}, timeout_err, 0);
    check({v.name, "_read_id"}, read_id, v.id);
    check({v.name, "_read_ts"}, read_ts, TS_EN ? v.ts : 32'h0);
    check({v.name, "_id_read_cycles"}, hi0, v.hi0);
    check({v.name, "_ts_read_cycles"}, hi1, TS_EN ? 1 : 0);
    check({v.name, "_first_read_cycle"}, (rises.size() > 0) ? rises[0] : -1, 1);
    check({v.name, "_busy_gaps"}, busy_low, 0);
  endtask

  task automatic reset_mid(input int at_c, input int wait_c, input logic exp_read);
    int dones;
    slave_cfg(32'h0, TS_OK, wait_c, 1'b0, 0, -1);
    @(posedge clock); #2; base = tcyc + 1;
    @(posedge clock); #2; start = 1'b1;
    for (int k = 1; k <= at_c; k++) begin
      @(posedge clock); #2;
      start = 1'b0;
    end
    check("rstmid_busy_before", busy, 1);
    check("rstmid_read_before", avm_read, exp_read);
    #1 reset = 1'b1;
    #1;
    check("rstmid_avm_read", avm_read, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_pass", pass, 0);
    check("rstmid_timeout_err", timeout_err, 0);
    check("rstmid_read_id", read_id, 0);
    check("rstmid_read_ts", read_ts, 0);
    dones = 0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    slave_cfg(32'h0, TS_OK, 0, 1'b0, 0, -1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #2;
      if (done || busy) dones++;
    end
    check("rstmid_no_done_after", dones, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    slave_cfg(32'h0, TS_OK, 0, 1'b0, 0, -1);

    vecs[0] = '{"nominal",    32'h0, TS_OK,         0, 1'b0,  5,  3, 1'b1, 1'b1, 1};
    vecs[1] = '{"bad_ts",     32'h0, 32'h1234_5678, 0, 1'b0,  5,  3, 1'b0, 1'b1, 1};
    vecs[2] = '{"bad_id",     32'h1, TS_OK,         0, 1'b0,  5,  3, 1'b0, 1'b0, 1};
    vecs[3] = '{"wait7",      32'h0, TS_OK,         7, 1'b0, 12, 10, 1'b1, 1'b1, 8};
    vecs[4] = '{"same_cycle", 32'h0, TS_OK,         0, 1'b1,  3,  2, 1'b1, 1'b1, 1};

    repeat (3) @(posedge clock);
    #2;
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_read_id", read_id, 0);
    check("rst_read_ts", read_ts, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    // Slave never answers; a start pulse mid-sequence must be ignored.
    slave_cfg(32'h0, TS_OK, 0, 1'b0, 1_000_000, -1);
    run_seq(6000, 500);
    check("tmo_done_cycle", done_c, 4145);
    check("tmo_timeout_err", timeout_err, 1);
    check("tmo_pass", pass, 0);
    check("tmo_issues", rises.size(), 4);
    check("tmo_id_read_cycles", hi0, 4);
    check("tmo_ts_read_cycles", hi1, 0);
    check("tmo_last_issue", (rises.size() == 4) ? rises[3] : -1, 3121);
    for (int i = 1; i < rises.size(); i++)
      check("tmo_issue_spacing", rises[i] - rises[i-1], 1040);

    // First ID read times out, junk arrives during GAP, retry succeeds.
    slave_cfg(32'h0, TS_OK, 0, 1'b0, 1025, 1030);
    run_seq(2000, -1);
    check("late_done_cycle", done_c, TS_EN ? 1045 : 1043);
    check("late_pass", pass, 1);
    check("late_timeout_err", timeout_err, 0);
    check("late_read_id", read_id, 0);
    check("late_issues", rises.size(), TS_EN ? 3 : 2);
    check("late_retry_cycle", (rises.size() > 1) ? rises[1] : -1, 1041);

    // readdatavalid while idle must not touch the captured words.
    @(posedge clock); #2;
    sl_inject = tcyc - base + 2;
    repeat (5) @(posedge clock);
    #2;
    check("idle_rdv_read_id", read_id, 0);
    check("idle_rdv_read_ts", read_ts, TS_EN ? TS_OK : 32'h0);
    check("idle_rdv_no_done", done, 0);
    sl_inject = -1;

    reset_mid(TS_EN ? 4 : 2, 0, 1'b0);
    reset_mid(3, 7, 1'b1);
    apply_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
